// File: rtl/l2_req_arbiter.sv
// Round-robin arbiter sharing one non-pipelined L2 request port between L1_D (0) and L1_I (1).
// Optional saturating per-requester grant counters are enabled with `define L2_ARB_PERF_CNT_EN.
module l2_req_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int WDATA_W = 64,
   parameter int LINE_W  = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [WDATA_W-1:0] d_wdata,
   input  logic [2:0]         d_size,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic               l2_valid,
   input  logic               l2_ready,
   output logic               l2_we,
   output logic [ADDR_W-1:0]  l2_addr,
   output logic [WDATA_W-1:0] l2_wdata,
   output logic [2:0]         l2_size,
   input  logic               l2_resp_valid,
   input  logic [LINE_W-1:0]  l2_resp_data,
   output logic [1:0]         resp_valid,
   output logic [LINE_W-1:0]  resp_data,
   output logic               busy
`ifdef L2_ARB_PERF_CNT_EN
   ,
   output logic [31:0]        d_grant_cnt,
   output logic [31:0]        i_grant_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t             state_r,      state_s;
   logic               owner_r,      owner_s;
   logic               ptr_r,        ptr_s;
   logic [1:0]         req_ready_r,  req_ready_s;
   logic               l2_valid_r,   l2_valid_s;
   logic               l2_we_r,      l2_we_s;
   logic [ADDR_W-1:0]  l2_addr_r,    l2_addr_s;
   logic [WDATA_W-1:0] l2_wdata_r,   l2_wdata_s;
   logic [2:0]         l2_size_r,    l2_size_s;
   logic [1:0]         resp_valid_r, resp_valid_s;
   logic [LINE_W-1:0]  resp_data_r,  resp_data_s;
   logic               busy_r,       busy_s;
   logic               grant_s;

   function automatic logic [1:0] onehot(input logic sel);
      return sel ? 2'b10 : 2'b01;
   endfunction

   // Requester selection: a lone requester wins, a conflict goes to ptr_r (the one not granted last)
   always_comb begin
      grant_s = 1'b0;
      if (req_valid == 2'b11) begin
         grant_s = ptr_r;
      end else if (req_valid[1]) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Next-state and next-output logic of the transaction FSM
   always_comb begin
      state_s      = state_r;
      owner_s      = owner_r;
      ptr_s        = ptr_r;
      req_ready_s  = 2'b00;
      l2_valid_s   = l2_valid_r;
      l2_we_s      = l2_we_r;
      l2_addr_s    = l2_addr_r;
      l2_wdata_s   = l2_wdata_r;
      l2_size_s    = l2_size_r;
      resp_valid_s = 2'b00;
      resp_data_s  = resp_data_r;
      case (state_r)
         ST_IDLE: begin
            if (req_valid != 2'b00) begin
               state_s     = ST_ISSUE;
               owner_s     = grant_s;
               ptr_s       = ~grant_s;
               req_ready_s = onehot(grant_s);
               if (grant_s) begin
                  l2_we_s    = 1'b0;
                  l2_addr_s  = i_addr;
                  l2_wdata_s = '0;
                  l2_size_s  = 3'd7;
               end else begin
                  l2_we_s    = d_we;
                  l2_addr_s  = d_addr;
                  l2_wdata_s = d_wdata;
                  l2_size_s  = d_size;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // First ISSUE cycle carries the accept pulse; the command is presented from the next one
            if (!l2_valid_r) begin
               l2_valid_s = 1'b1;
            end else if (l2_ready) begin
               l2_valid_s = 1'b0;
               if (l2_resp_valid) begin
                  resp_data_s  = l2_resp_data;
                  resp_valid_s = onehot(owner_r);
                  state_s      = ST_RESP;
               end else begin
                  state_s = ST_WAIT;
               end
            end else begin
               state_s = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            if (l2_resp_valid) begin
               resp_data_s  = l2_resp_data;
               resp_valid_s = onehot(owner_r);
               state_s      = ST_RESP;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_RESP: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s    = ST_IDLE;
            l2_valid_s = 1'b0;
         end
      endcase
      busy_s = (state_s != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         owner_r      <= 1'b0;
         ptr_r        <= 1'b0;
         req_ready_r  <= 2'b00;
         l2_valid_r   <= 1'b0;
         l2_we_r      <= 1'b0;
         l2_addr_r    <= '0;
         l2_wdata_r   <= '0;
         l2_size_r    <= 3'd0;
         resp_valid_r <= 2'b00;
         resp_data_r  <= '0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         owner_r      <= owner_s;
         ptr_r        <= ptr_s;
         req_ready_r  <= req_ready_s;
         l2_valid_r   <= l2_valid_s;
         l2_we_r      <= l2_we_s;
         l2_addr_r    <= l2_addr_s;
         l2_wdata_r   <= l2_wdata_s;
         l2_size_r    <= l2_size_s;
         resp_valid_r <= resp_valid_s;
         resp_data_r  <= resp_data_s;
         busy_r       <= busy_s;
      end
   end

   assign req_ready  = req_ready_r;
   assign l2_valid   = l2_valid_r;
   assign l2_we      = l2_we_r;
   assign l2_addr    = l2_addr_r;
   assign l2_wdata   = l2_wdata_r;
   assign l2_size    = l2_size_r;
   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_data_r;
   assign busy       = busy_r;

`ifdef L2_ARB_PERF_CNT_EN
   logic [31:0] d_cnt_r;
   logic [31:0] i_cnt_r;

   // Saturating grant counters, stepped together with the accept pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_cnt_r <= 32'd0;
         i_cnt_r <= 32'd0;
      end else begin
         if (req_ready_s[0] && (d_cnt_r != 32'hFFFF_FFFF)) begin
            d_cnt_r <= d_cnt_r + 32'd1;
         end
         if (req_ready_s[1] && (i_cnt_r != 32'hFFFF_FFFF)) begin
            i_cnt_r <= i_cnt_r + 32'd1;
         end
      end
   end

   assign d_grant_cnt = d_cnt_r;
   assign i_grant_cnt = i_cnt_r;
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin reference model.
module tb_l2_req_arbiter;
   localparam int ADDR_W  = 64;
   localparam int WDATA_W = 64;
   localparam int LINE_W  = 128;

   logic               clk           = 1'b0;
   logic               rst_n         = 1'b0;
   logic [1:0]         req_valid     = 2'b00;
   logic [1:0]         req_ready;
   logic               d_we          = 1'b0;
   logic [ADDR_W-1:0]  d_addr        = 64'd0;
   logic [WDATA_W-1:0] d_wdata       = 64'd0;
   logic [2:0]         d_size        = 3'd0;
   logic [ADDR_W-1:0]  i_addr        = 64'd0;
   logic               l2_valid;
   logic               l2_ready      = 1'b0;
   logic               l2_we;
   logic [ADDR_W-1:0]  l2_addr;
   logic [WDATA_W-1:0] l2_wdata;
   logic [2:0]         l2_size;
   logic               l2_resp_valid = 1'b0;
   logic [LINE_W-1:0]  l2_resp_data  = 128'd0;
   logic [1:0]         resp_valid;
   logic [LINE_W-1:0]  resp_data;
   logic               busy;
`ifdef L2_ARB_PERF_CNT_EN
   logic [31:0]        d_grant_cnt;
   logic [31:0]        i_grant_cnt;
`endif

   int errors = 0;
   int checks = 0;
   logic mdl_last_i = 1'b1;   // 1 when L1_I was granted last (reset state: L1_D wins a conflict)

   typedef struct packed {
      logic         timeout;
      logic [7:0]   glat;
      logic [1:0]   grant;
      logic         valid_n1;
      logic         we;
      logic [63:0]  addr;
      logic [63:0]  wdata;
      logic [2:0]   size;
      logic         stable;
      logic [7:0]   valid_cycles;
      logic         valid_drop;
      logic         early;
      logic         busy_ok;
      logic [1:0]   rv;
      logic [127:0] rdata;
      logic [1:0]   rv_after;
      logic         busy_after;
   } obs_t;

   l2_req_arbiter #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size), .i_addr(i_addr),
      .l2_valid(l2_valid), .l2_ready(l2_ready), .l2_we(l2_we), .l2_addr(l2_addr),
      .l2_wdata(l2_wdata), .l2_size(l2_size), .l2_resp_valid(l2_resp_valid),
      .l2_resp_data(l2_resp_data), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
`ifdef L2_ARB_PERF_CNT_EN
      , .d_grant_cnt(d_grant_cnt), .i_grant_cnt(i_grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Invariant: accept and response strobes are one-hot-or-zero and never coincide
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checks++;
         if ((req_ready == 2'b11) || (resp_valid == 2'b11) ||
             ((req_ready != 2'b00) && (resp_valid != 2'b00))) begin
            errors++;
            $display("FAIL strobe_invariant: req_ready=%b resp_valid=%b at %0t", req_ready, resp_valid, $time);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: a lone requester wins; on conflict the one not granted last wins
   function automatic logic [1:0] mdl_winner(input logic [1:0] rv);
      if (rv == 2'b01) return 2'b01;
      if (rv == 2'b10) return 2'b10;
      return mdl_last_i ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [131:0] mdl_cmd(input logic [1:0] w);
      if (w == 2'b10) return {1'b0, i_addr, 64'd0, 3'd7};
      return {d_we, d_addr, d_wdata, d_size};
   endfunction

   task automatic rand_inputs();
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = {$urandom(), $urandom()};
      d_wdata = {$urandom(), $urandom()};
      d_size  = 3'($urandom_range(0, 7));
      i_addr  = {$urandom(), $urandom()};
   endtask

   // Drives one complete transaction and records what the DUT did
   task automatic do_txn(input logic [1:0] rv, input logic keep, input int rdly, input int pdly,
                         input logic [127:0] data, output obs_t o);
      o = '0;
      o.timeout = 1'b1;
      req_valid = rv;
      for (int i = 0; i < 20; i++) begin
         step();
         o.glat = o.glat + 8'd1;
         if (req_ready != 2'b00) begin
            o.timeout = 1'b0;
            break;
         end
      end
      if (o.timeout) begin
         req_valid = 2'b00;
         return;
      end
      o.grant   = req_ready;
      o.busy_ok = busy;
      if (!keep) req_valid = rv & ~req_ready;
      step();
      o.valid_n1 = l2_valid;
      {o.we, o.addr, o.wdata, o.size} = {l2_we, l2_addr, l2_wdata, l2_size};
      o.stable       = 1'b1;
      o.valid_cycles = l2_valid ? 8'd1 : 8'd0;
      o.busy_ok      = o.busy_ok & busy;
      for (int i = 0; i < rdly; i++) begin
         step();
         if (l2_valid) o.valid_cycles = o.valid_cycles + 8'd1;
         if (!l2_valid || ({l2_we, l2_addr, l2_wdata, l2_size} != {o.we, o.addr, o.wdata, o.size}))
            o.stable = 1'b0;
      end
      l2_ready = 1'b1;
      if (pdly == 0) begin
         l2_resp_valid = 1'b1;
         l2_resp_data  = data;
      end
      step();
      l2_ready      = 1'b0;
      l2_resp_valid = 1'b0;
      o.valid_drop  = !l2_valid;
      if (pdly > 0) begin
         for (int i = 1; i < pdly; i++) begin
            if (resp_valid != 2'b00 || !busy) o.early = 1'b1;
            step();
         end
         if (resp_valid != 2'b00 || !busy) o.early = 1'b1;
         l2_resp_valid = 1'b1;
         l2_resp_data  = data;
         step();
         l2_resp_valid = 1'b0;
      end
      o.rv      = resp_valid;
      o.rdata   = resp_data;
      o.busy_ok = o.busy_ok & busy;
      step();
      o.rv_after   = resp_valid;
      o.busy_after = busy;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      step();
      step();
      rst_n = 1'b1;
      step();
      mdl_last_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if ({req_ready, l2_valid, l2_we, l2_addr, l2_wdata, l2_size, resp_valid, resp_data, busy} !== 266'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 0",
                  {req_ready, l2_valid, l2_we, l2_addr, l2_wdata, l2_size, resp_valid, resp_data, busy});
      end
      rst_n = 1'b1;
      step();
      step();
      checks++;
      if ({req_ready, l2_valid, resp_valid, busy} !== 6'd0) begin
         errors++;
         $display("FAIL reset_idle: got %b want 0", {req_ready, l2_valid, resp_valid, busy});
      end
      mdl_last_i = 1'b1;
   endtask

   task automatic test_single_d_read();
      obs_t o;
      logic [131:0] exp;
      d_we = 1'b0; d_addr = 64'h1040; d_wdata = {$urandom(), $urandom()}; d_size = 3'd3;
      exp = mdl_cmd(2'b01);
      do_txn(2'b01, 1'b0, 0, 2, 128'hA5, o);
      mdl_last_i = 1'b0;
      checks++;
      if ({o.timeout, o.grant, o.glat} !== {1'b0, 2'b01, 8'd1}) begin
         errors++;
         $display("FAIL d_read_grant: got to=%b g=%b lat=%0d want 0/01/1", o.timeout, o.grant, o.glat);
      end
      checks++;
      if ({o.valid_n1, o.we, o.addr, o.wdata, o.size} !== {1'b1, exp}) begin
         errors++;
         $display("FAIL d_read_cmd: got v=%b addr=%h want v=1 addr=%h", o.valid_n1, o.addr, exp[130:67]);
      end
      checks++;
      if ({o.rv, o.rdata} !== {2'b01, 128'hA5}) begin
         errors++;
         $display("FAIL d_read_resp: got rv=%b data=%h want 01/a5", o.rv, o.rdata);
      end
      checks++;
      if ({o.valid_drop, o.early, o.busy_ok, o.rv_after, o.busy_after} !== {1'b1, 1'b0, 1'b1, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL d_read_proto: got drop=%b early=%b busy=%b rv_after=%b busy_after=%b",
                  o.valid_drop, o.early, o.busy_ok, o.rv_after, o.busy_after);
      end
   endtask

   task automatic test_simultaneous();
      obs_t o;
      logic [1:0] w;
      logic [131:0] exp;
      do_reset();
      rand_inputs();
      w = mdl_winner(2'b11);
      do_txn(2'b11, 1'b0, 0, 1, {$urandom(), $urandom(), $urandom(), $urandom()}, o);
      mdl_last_i = (w == 2'b10);
      checks++;
      if (o.grant !== w) begin
         errors++;
         $display("FAIL simul_first: got %b want %b", o.grant, w);
      end
      w   = mdl_winner(req_valid);
      exp = mdl_cmd(w);
      do_txn(req_valid, 1'b0, 1, 1, 128'h1234, o);
      mdl_last_i = (w == 2'b10);
      checks++;
      if ({o.grant, o.we, o.addr, o.wdata, o.size, o.rv} !== {w, exp, w}) begin
         errors++;
         $display("FAIL simul_second: got g=%b we=%b sz=%0d rv=%b want g=%b we=0 sz=7", o.grant, o.we, o.size, o.rv, w);
      end
   endtask

   task automatic test_fairness();
      obs_t o;
      logic [1:0] w;
      logic [1:0] prev = 2'b00;
      for (int i = 0; i < 6; i++) begin
         rand_inputs();
         w = mdl_winner(2'b11);
         do_txn(2'b11, 1'b1, i % 3, i % 2, {4{$urandom()}}, o);
         mdl_last_i = (w == 2'b10);
         checks++;
         if (o.grant !== w) begin
            errors++;
            $display("FAIL fair_grant[%0d]: got %b want %b", i, o.grant, w);
         end
         if (i > 0) begin
            checks++;
            if (o.grant !== ~prev) begin
               errors++;
               $display("FAIL fair_alternate[%0d]: got %b want %b", i, o.grant, ~prev);
            end
         end
         prev = o.grant;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_d_write();
      obs_t o;
      logic [131:0] exp;
      logic [127:0] ack;
      d_we = 1'b1; d_wdata = 64'hDEAD; d_size = 3'd3; d_addr = {$urandom(), $urandom()};
      exp = mdl_cmd(2'b01);
      ack = {$urandom(), $urandom(), $urandom(), $urandom()};
      do_txn(2'b01, 1'b0, 4, 1, ack, o);
      mdl_last_i = 1'b0;
      checks++;
      if ({o.grant, o.we, o.addr, o.wdata, o.size} !== {2'b01, exp}) begin
         errors++;
         $display("FAIL d_write_cmd: got g=%b we=%b wdata=%h sz=%0d", o.grant, o.we, o.wdata, o.size);
      end
      checks++;
      if ({o.stable, o.valid_cycles} !== {1'b1, 8'd5}) begin
         errors++;
         $display("FAIL d_write_hold: got stable=%b cycles=%0d want 1/5", o.stable, o.valid_cycles);
      end
      checks++;
      if ({o.rv, o.rdata} !== {2'b01, ack}) begin
         errors++;
         $display("FAIL d_write_ack: got rv=%b data=%h want 01/%h", o.rv, o.rdata, ack);
      end
   endtask

   task automatic test_stray_resp();
      obs_t o;
      logic [127:0] held;
      logic [1:0] w;
      held = {$urandom(), $urandom(), $urandom(), $urandom()};
      rand_inputs();
      do_txn(2'b01, 1'b0, 0, 1, held, o);
      mdl_last_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         l2_resp_valid = 1'b1;
         l2_resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         checks++;
         if ({resp_valid, busy, resp_data} !== {3'b000, held}) begin
            errors++;
            $display("FAIL stray_resp[%0d]: got rv=%b busy=%b data=%h", i, resp_valid, busy, resp_data);
         end
      end
      l2_resp_valid = 1'b0;
      rand_inputs();
      w = mdl_winner(2'b10);
      do_txn(2'b10, 1'b0, 0, 0, 128'h77, o);
      mdl_last_i = 1'b1;
      checks++;
      if ({o.grant, o.rv, o.rdata} !== {w, w, 128'h77}) begin
         errors++;
         $display("FAIL stray_after: got g=%b rv=%b data=%h", o.grant, o.rv, o.rdata);
      end
   endtask

   task automatic test_reset_wait();
      obs_t o;
      logic [131:0] exp;
      rand_inputs();
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      l2_ready = 1'b1;
      step();
      l2_ready = 1'b0;
      checks++;
      if ({l2_valid, busy} !== 2'b01) begin
         errors++;
         $display("FAIL rstwait_setup: got l2_valid=%b busy=%b want 0/1", l2_valid, busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, l2_valid, l2_we, l2_addr, l2_wdata, l2_size, resp_valid, resp_data, busy} !== 266'd0) begin
         errors++;
         $display("FAIL rstwait_async: got %h want 0",
                  {req_ready, l2_valid, l2_we, l2_addr, l2_wdata, l2_size, resp_valid, resp_data, busy});
      end
      l2_resp_valid = 1'b1;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({resp_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL rstwait_abandon[%0d]: got rv=%b busy=%b", i, resp_valid, busy);
         end
      end
      l2_resp_valid = 1'b0;
      mdl_last_i = 1'b1;
      rand_inputs();
      do_txn(2'b11, 1'b0, 0, 1, 128'h5, o);
      checks++;
      if (o.grant !== mdl_winner(2'b11)) begin
         errors++;
         $display("FAIL rstwait_ptr: got %b want %b", o.grant, mdl_winner(2'b11));
      end
      mdl_last_i = 1'b0;
      req_valid = 2'b00;
      exp = mdl_cmd(2'b10);
      do_txn(2'b10, 1'b0, 1, 2, 128'h9, o);
      mdl_last_i = 1'b1;
      checks++;
      if ({o.grant, o.we, o.addr, o.wdata, o.size, o.rv, o.rdata} !== {2'b10, exp, 2'b10, 128'h9}) begin
         errors++;
         $display("FAIL rstwait_i_req: got g=%b addr=%h rv=%b", o.grant, o.addr, o.rv);
      end
   endtask

   task automatic test_random();
      obs_t o;
      logic [1:0] rv;
      logic [1:0] w;
      logic [131:0] exp;
      logic [127:0] data;
      int rdly;
      for (int i = 0; i < 40; i++) begin
         rand_inputs();
         rv   = 2'($urandom_range(1, 3));
         rdly = $urandom_range(0, 3);
         data = {$urandom(), $urandom(), $urandom(), $urandom()};
         w    = mdl_winner(rv);
         exp  = mdl_cmd(w);
         do_txn(rv, 1'($urandom_range(0, 1)), rdly, $urandom_range(0, 3), data, o);
         mdl_last_i = (w == 2'b10);
         checks++;
         if ({o.timeout, o.grant, o.glat} !== {1'b0, w, 8'd1}) begin
            errors++;
            $display("FAIL rnd_grant[%0d]: got to=%b g=%b lat=%0d want g=%b", i, o.timeout, o.grant, o.glat, w);
         end
         checks++;
         if ({o.we, o.addr, o.wdata, o.size} !== exp) begin
            errors++;
            $display("FAIL rnd_cmd[%0d]: got %h want %h", i, {o.we, o.addr, o.wdata, o.size}, exp);
         end
         checks++;
         if ({o.valid_n1, o.stable, o.valid_cycles, o.valid_drop, o.early, o.busy_ok} !==
             {1'b1, 1'b1, 8'(rdly + 1), 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rnd_proto[%0d]: got v=%b st=%b cyc=%0d drop=%b early=%b busy=%b", i,
                     o.valid_n1, o.stable, o.valid_cycles, o.valid_drop, o.early, o.busy_ok);
         end
         checks++;
         if ({o.rv, o.rdata, o.rv_after, o.busy_after} !== {w, data, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL rnd_resp[%0d]: got rv=%b data=%h after=%b busy=%b want rv=%b data=%h", i,
                     o.rv, o.rdata, o.rv_after, o.busy_after, w, data);
         end
      end
      req_valid = 2'b00;
   endtask

`ifdef L2_ARB_PERF_CNT_EN
   task automatic test_perf_cnt();
      obs_t o;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rand_inputs();
         do_txn((i < 3) ? 2'b01 : 2'b10, 1'b0, 0, 1, 128'h1, o);
      end
      checks++;
      if ({d_grant_cnt, i_grant_cnt} !== {32'd3, 32'd2}) begin
         errors++;
         $display("FAIL perf_cnt: got d=%0d i=%0d want 3/2", d_grant_cnt, i_grant_cnt);
      end
      mdl_last_i = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_single_d_read();
      test_simultaneous();
      test_fairness();
      test_d_write();
      test_stray_resp();
      test_reset_wait();
      test_random();
`ifdef L2_ARB_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
